sram_write_ctrl: RTL and testbench

Frame-buffer write stage directly downstream of the SPI instruction decoder. Consumes the decoder's CASET/RASET window, pixel write strobes and SWRESET clear request; converts them into linear SRAM word addresses with window wrap-around; buffers them in a small FIFO; and drives a request/grant write port toward the frame-buffer SRAM arbiter. It also performs the full-memory clear sweep.

---
 rtl/sram_write_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sram_write_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_ctrl.sv
// Frame-buffer write stage: window/cursor to linear SRAM address, pending-write FIFO, clear sweep.
// One-cycle pixel-to-request latency; requests hold until granted, a full FIFO drops pixels and sets o_ovf.

module sram_wr_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_pdat,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_pdat;
    end
endmodule

module sram_write_ctrl #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 128,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_pixel_data,
    input  logic [31:0]       i_col_addr,
    input  logic [31:0]       i_row_addr,
    input  logic              i_clr_req,
    input  logic              i_write_req,
    input  logic              i_waddr_set_req,
    input  logic              i_sram_gnt,
    output logic              o_sram_req,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_wdata,
    output logic              o_busy,
    output logic              o_ovf
);
    localparam int ENT_W = ADDR_W + 16;
    localparam logic [15:0]       LP_XMAX   = 16'(H_RES - 1);
    localparam logic [15:0]       LP_YMAX   = 16'(V_RES - 1);
    localparam logic [15:0]       LP_HRES   = 16'(H_RES);
    localparam logic [15:0]       LP_VRES   = 16'(V_RES);
    localparam logic [ADDR_W-1:0] LP_HRES_A = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] LP_LAST   = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_sweep;
    logic [ADDR_W-1:0]  w_sweep_nxt;
    logic               r_ovf;
    logic [15:0]        r_xs, r_xe, r_ys, r_ye, r_cx, r_cy;

    logic [15:0]        w_xs_n, w_xe_c, w_xe_n, w_ys_n, w_ye_c, w_ye_n;
    logic [15:0]        w_xs, w_xe, w_ys, w_ye, w_cx, w_cy;
    logic [15:0]        w_cx_nxt, w_cy_nxt;
    logic               w_wr, w_in_range, w_push, w_pop;
    logic [ADDR_W-1:0]  w_addr;
    logic [ENT_W-1:0]   w_head;
    logic               w_empty, w_full;

    // Window as it would be latched this cycle; a simultaneous write uses it immediately.
    assign w_xs_n = i_col_addr[31:16];
    assign w_xe_c = (i_col_addr[15:0] > LP_XMAX) ? LP_XMAX : i_col_addr[15:0];
    assign w_xe_n = (w_xs_n > w_xe_c) ? w_xs_n : w_xe_c;
    assign w_ys_n = i_row_addr[31:16];
    assign w_ye_c = (i_row_addr[15:0] > LP_YMAX) ? LP_YMAX : i_row_addr[15:0];
    assign w_ye_n = (w_ys_n > w_ye_c) ? w_ys_n : w_ye_c;

    assign w_xs = i_waddr_set_req ? w_xs_n : r_xs;
    assign w_xe = i_waddr_set_req ? w_xe_n : r_xe;
    assign w_ys = i_waddr_set_req ? w_ys_n : r_ys;
    assign w_ye = i_waddr_set_req ? w_ye_n : r_ye;
    assign w_cx = i_waddr_set_req ? w_xs_n : r_cx;
    assign w_cy = i_waddr_set_req ? w_ys_n : r_cy;

    assign w_cx_nxt = (w_cx == w_xe) ? w_xs : w_cx + 16'd1;
    assign w_cy_nxt = (w_cx != w_xe) ? w_cy : ((w_cy == w_ye) ? w_ys : w_cy + 16'd1);

    assign w_wr       = i_write_req && (r_state == ST_IDLE) && !i_clr_req;
    assign w_in_range = (w_cx < LP_HRES) && (w_cy < LP_VRES);
    assign w_push     = w_wr && w_in_range;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty && i_sram_gnt;
    assign w_addr     = ADDR_W'(w_cy) * LP_HRES_A + ADDR_W'(w_cx);

    sram_wr_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_clr_req),
        .i_push  (w_push),
        .i_pdat  ({w_addr, i_pixel_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        if (i_clr_req) begin
            w_state_nxt = ST_CLEAR;
            w_sweep_nxt = '0;
        end else if ((r_state == ST_CLEAR) && i_sram_gnt) begin
            if (r_sweep == LP_LAST) w_state_nxt = ST_IDLE;
            else                    w_sweep_nxt = r_sweep + ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xs  <= '0;
            r_xe  <= '0;
            r_ys  <= '0;
            r_ye  <= '0;
            r_cx  <= '0;
            r_cy  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (i_waddr_set_req) begin
                r_xs <= w_xs_n;
                r_xe <= w_xe_n;
                r_ys <= w_ys_n;
                r_ye <= w_ye_n;
            end
            if (w_wr) begin
                r_cx <= w_cx_nxt;
                r_cy <= w_cy_nxt;
            end else if (i_waddr_set_req) begin
                r_cx <= w_xs_n;
                r_cy <= w_ys_n;
            end
            if (i_clr_req)                      r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Idle outputs are forced to zero so stale FIFO storage never leaks onto the port.
    assign o_busy       = (r_state == ST_CLEAR);
    assign o_ovf        = r_ovf;
    assign o_sram_req   = o_busy || !w_empty;
    assign o_sram_addr  = o_busy ? r_sweep : (w_empty ? '0 : w_head[ENT_W-1:16]);
    assign o_sram_wdata = (o_busy || w_empty) ? 16'd0 : w_head[15:0];
endmodule

// File: tb/tb_sram_write_ctrl.sv
module tb_sram_write_ctrl;
    localparam int H   = 160;
    localparam int V   = 128;
    localparam int TOT = H * V;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_pixel_data = '0;
    logic [31:0] i_col_addr = '0;
    logic [31:0] i_row_addr = '0;
    logic        i_clr_req = 1'b0;
    logic        i_write_req = 1'b0;
    logic        i_waddr_set_req = 1'b0;
    logic        i_sram_gnt = 1'b0;
    logic        o_sram_req;
    logic [14:0] o_sram_addr;
    logic [15:0] o_sram_wdata;
    logic        o_busy;
    logic        o_ovf;

    sram_write_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(15), .FIFO_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pixel_data(i_pixel_data),
        .i_col_addr(i_col_addr), .i_row_addr(i_row_addr), .i_clr_req(i_clr_req),
        .i_write_req(i_write_req), .i_waddr_set_req(i_waddr_set_req), .i_sram_gnt(i_sram_gnt),
        .o_sram_req(o_sram_req), .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
        .o_busy(o_busy), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [14:0] a;
        logic [15:0] d;
    } ent_t;

    int   n_chk = 0;
    int   n_pass = 0;
    ent_t mq[$];
    ent_t xlog[$];
    int   m_xs, m_xe, m_ys, m_ye, m_cx, m_cy, m_sweep;
    bit   m_busy, m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic m_reset();
        mq.delete();
        m_xs = 0; m_xe = 0; m_ys = 0; m_ye = 0; m_cx = 0; m_cy = 0;
        m_sweep = 0; m_busy = 0; m_ovf = 0;
    endtask

    task automatic m_latch(input logic [31:0] col, input logic [31:0] row);
        m_xs = int'(col[31:16]);
        m_xe = int'(col[15:0]);
        if (m_xe > H - 1) m_xe = H - 1;
        if (m_xs > m_xe)  m_xe = m_xs;
        m_ys = int'(row[31:16]);
        m_ye = int'(row[15:0]);
        if (m_ye > V - 1) m_ye = V - 1;
        if (m_ys > m_ye)  m_ye = m_ys;
        m_cx = m_xs;
        m_cy = m_ys;
    endtask

    task automatic m_step(input bit clr, input bit wr, input bit set, input bit gnt,
                          input logic [15:0] pd, input logic [31:0] col, input logic [31:0] row);
        ent_t e;
        if (set) m_latch(col, row);
        if (clr) begin
            mq.delete();
            m_ovf = 0; m_busy = 1; m_sweep = 0;
        end else if (m_busy) begin
            if (gnt) begin
                if (m_sweep == TOT - 1) m_busy = 0;
                else m_sweep++;
            end
        end else begin
            if (gnt && mq.size() > 0) void'(mq.pop_front());
            if (wr) begin
                if (m_cx < H && m_cy < V) begin
                    e.a = 15'(m_cy * H + m_cx);
                    e.d = pd;
                    if (mq.size() < 4) mq.push_back(e);
                    else m_ovf = 1;
                end
                if (m_cx == m_xe) begin
                    m_cx = m_xs;
                    m_cy = (m_cy == m_ye) ? m_ys : m_cy + 1;
                end else m_cx++;
            end
        end
    endtask

    // Checks the outputs of the current cycle, applies inputs, advances one clock.
    task automatic cycle(input bit clr, input bit wr, input bit set, input bit gnt,
                         input logic [15:0] pd, input logic [31:0] col, input logic [31:0] row);
        bit   er;
        ent_t e;
        er = m_busy || (mq.size() > 0);
        chk("req", 32'(o_sram_req), 32'(er));
        if (er) begin
            chk("addr", 32'(o_sram_addr), m_busy ? m_sweep : 32'(mq[0].a));
            chk("wdata", 32'(o_sram_wdata), m_busy ? 32'd0 : 32'(mq[0].d));
        end
        chk("busy", 32'(o_busy), 32'(m_busy));
        chk("ovf", 32'(o_ovf), 32'(m_ovf));
        if (o_sram_req && gnt) begin
            e.a = o_sram_addr;
            e.d = o_sram_wdata;
            xlog.push_back(e);
        end
        i_clr_req = clr; i_write_req = wr; i_waddr_set_req = set; i_sram_gnt = gnt;
        i_pixel_data = pd; i_col_addr = col; i_row_addr = row;
        m_step(clr, wr, set, gnt, pd, col, row);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n, input bit gnt);
        repeat (n) cycle(0, 0, 0, gnt, 16'd0, 32'd0, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_a[10];
        int cnt;
        int err;
        bit gnt;
        exp_a = '{162, 163, 164, 322, 323, 324, 482, 483, 484, 162};

        m_reset();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_req", 32'(o_sram_req), 0);
        chk("rst_addr", 32'(o_sram_addr), 0);
        chk("rst_wdata", 32'(o_sram_wdata), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        i_rst = 1'b0;

        // Reset cursor is (0,0) inside a 1x1 window.
        cycle(0, 1, 0, 0, 16'hABCD, 32'd0, 32'd0);
        chk("rst_cursor_addr", 32'(o_sram_addr), 0);
        chk("rst_cursor_data", 32'(o_sram_wdata), 32'hABCD);
        idle(2, 1);

        // 3x3 window at (2..4, 1..3); tenth write wraps to the top-left.
        cycle(0, 0, 1, 1, 16'd0, 32'h0002_0004, 32'h0001_0003);
        xlog.delete();
        for (int d = 1; d <= 10; d++) cycle(0, 1, 0, 1, 16'(d), 32'd0, 32'd0);
        idle(3, 1);
        chk("win_count", 32'(xlog.size()), 10);
        for (int i = 0; i < 10 && i < xlog.size(); i++) begin
            chk("win_addr", 32'(xlog[i].a), exp_a[i]);
            chk("win_data", 32'(xlog[i].d), i + 1);
        end

        // Latch and write in the same cycle: the pixel lands at the new origin.
        xlog.delete();
        cycle(0, 1, 1, 1, 16'd77, 32'h0005_0005, 32'h0002_0002);
        idle(2, 1);
        chk("same_cyc_addr", xlog.size() > 0 ? 32'(xlog[0].a) : 32'hFFFF, 2 * H + 5);

        // Clamp: xe 0xFF -> 159.
        cycle(0, 0, 1, 1, 16'd0, 32'h009E_00FF, 32'd0);
        xlog.delete();
        for (int d = 0; d < 3; d++) cycle(0, 1, 0, 1, 16'(d + 40), 32'd0, 32'd0);
        idle(2, 1);
        chk("clamp_count", 32'(xlog.size()), 3);
        if (xlog.size() == 3) begin
            chk("clamp_a0", 32'(xlog[0].a), 158);
            chk("clamp_a1", 32'(xlog[1].a), 159);
            chk("clamp_a2", 32'(xlog[2].a), 158);
        end
        cycle(0, 0, 1, 1, 16'd0, 32'h00A0_00A0, 32'd0);
        cycle(0, 1, 0, 1, 16'h1234, 32'd0, 32'd0);
        chk("discard_req", 32'(o_sram_req), 0);
        chk("discard_ovf", 32'(o_ovf), 0);

        // Overflow with grant low.
        cycle(0, 0, 1, 0, 16'd0, 32'h0000_0009, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 0, 0, 16'(32'h100 + i), 32'd0, 32'd0);
            if (i == 3) chk("ovf_after4", 32'(o_ovf), 0);
            if (i == 4) chk("ovf_after5", 32'(o_ovf), 1);
        end
        xlog.delete();
        idle(8, 1);
        chk("ovf_drain_count", 32'(xlog.size()), 4);
        for (int i = 0; i < 4 && i < xlog.size(); i++) begin
            chk("ovf_drain_addr", 32'(xlog[i].a), i);
            chk("ovf_drain_data", 32'(xlog[i].d), 32'h100 + i);
        end

        // Clear with two entries pending; a write mid-sweep is ignored.
        cycle(0, 1, 0, 0, 16'h0AA0, 32'd0, 32'd0);
        cycle(0, 1, 0, 0, 16'h0AA1, 32'd0, 32'd0);
        cycle(1, 0, 0, 1, 16'd0, 32'd0, 32'd0);
        chk("clr_entry_addr", 32'(o_sram_addr), 0);
        xlog.delete();
        cnt = 0;
        while (o_busy === 1'b1 && cnt < TOT + 10) begin
            cnt++;
            cycle(0, cnt == 50, 0, 1, 16'h5555, 32'd0, 32'd0);
        end
        chk("clr_busy_cycles", 32'(cnt), TOT);
        chk("clr_xfer_count", 32'(xlog.size()), TOT);
        err = 0;
        foreach (xlog[i]) if (int'(xlog[i].a) != (i % 32768) || xlog[i].d != 16'd0) err++;
        chk("clr_sequence_errors", 32'(err), 0);
        chk("clr_ovf_cleared", 32'(o_ovf), 0);
        chk("clr_flushed_req", 32'(o_sram_req), 0);

        // Restart at sweep address 100.
        cycle(1, 0, 0, 1, 16'd0, 32'd0, 32'd0);
        idle(100, 1);
        chk("restart_at100", 32'(o_sram_addr), 100);
        cycle(1, 0, 0, 1, 16'd0, 32'd0, 32'd0);
        chk("restart_addr0", 32'(o_sram_addr), 0);
        cnt = 0;
        while (o_busy === 1'b1 && cnt < TOT + 10) begin
            cnt++;
            cycle(0, 0, 0, 1, 16'd0, 32'd0, 32'd0);
        end
        chk("restart_len", 32'(cnt), TOT);

        // Asynchronous reset mid-sweep with grant low.
        cycle(1, 0, 0, 1, 16'd0, 32'd0, 32'd0);
        idle(37, 1);
        idle(3, 0);
        chk("held_addr", 32'(o_sram_addr), 37);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_req", 32'(o_sram_req), 0);
        chk("arst_addr", 32'(o_sram_addr), 0);
        chk("arst_wdata", 32'(o_sram_wdata), 0);
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_ovf", 32'(o_ovf), 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        m_reset();
        idle(3, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            if (n < 1500) gnt = ($urandom_range(0, 3) != 0);
            else          gnt = ($urandom_range(0, 3) == 0);
            cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, gnt,
                  16'($urandom),
                  {16'($urandom_range(0, 170)), 16'($urandom_range(0, 200))},
                  {16'($urandom_range(0, 135)), 16'($urandom_range(0, 150))});
        end
        idle(6, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
